uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter that shares one UART transmitter (8N1 framed, start/ready handshake)
//  between NUM_CLI byte producers. Accepts one byte per grant via valid/ready and launches
//  it with a one-cycle uart_tx_start. Holds off the next grant until the transmitter reports idle.
//  Sits between the application byte sources and the UART transmitter instance.
// PARAMETERS
//  NUM_CLI   4   number of requesting clients (2..8)
//  ID_W      2   width of grant_id; must be >= clog2(NUM_CLI)
// PORTS
//  clk           in   1          system clock; all state on posedge
//  rst_n         in   1          asynchronous, active-low reset
//  cli_valid     in   NUM_CLI    client i has a byte on cli_data[8*i+:8]
//  cli_data      in   8*NUM_CLI  packed client bytes
//  cli_last      in   NUM_CLI    byte is last of a packet (used only with UART_ARB_LOCK_EN)
//  cli_ready     out  NUM_CLI    one-hot accept; byte i taken when cli_valid[i]&cli_ready[i]
//  uart_tx_start out  1          one-cycle launch pulse to transmitter
//  uart_tx_buf   out  8          byte to transmitter; stable from START until the next accept
//  uart_tx_ready in   1          transmitter idle; low while its start input is high or a frame runs
//  grant_id      out  ID_W       index of the client of the last accepted byte
//  busy          out  1          high in START or BUSY state
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, uart_tx_start=0, uart_tx_buf=8'h00, cli_ready=0,
//   grant_id=0, busy=0, rr_ptr=NUM_CLI-1 (client 0 has highest priority first), lock cleared.
//  FSM IDLE -> START -> BUSY -> IDLE:
//   IDLE : if uart_tx_ready=1 and any eligible cli_valid: winner = first valid index after
//          rr_ptr (wrapping NUM_CLI-1 -> 0); cli_ready[winner]=1 combinationally this cycle;
//          on clk: uart_tx_buf<=cli_data[winner], grant_id<=winner, rr_ptr<=winner, -> START.
//          If uart_tx_ready=0 (e.g. frame still running after our reset): no grant, stay.
//   START: uart_tx_start=1 for exactly this cycle; uart_tx_ready is ignored here; -> BUSY.
//   BUSY : uart_tx_start=0; wait for uart_tx_ready=1, then -> IDLE (no grant in this cycle).
//  Latency: accept cycle N, uart_tx_start at N+1; next accept no earlier than the first cycle
//   after uart_tx_ready returns high, i.e. at least 3 cycles between accepts.
//  cli_ready is 0 in START and BUSY; at most one bit set; never set for a client with valid=0.
//  Single valid client: served on every IDLE opportunity (no idle gap forced by round robin).
//  Client dropping valid before accept: not penalised; rr_ptr changes only on accept.
//  cli_data sampled only in the accept cycle; later changes do not affect uart_tx_buf.
//  Reset asserted mid-START/BUSY: uart_tx_start drops immediately; the byte in flight may
//   still be framed by the transmitter; after reset IDLE waits on uart_tx_ready.
// CONFIGURATION
//  UART_ARB_LOCK_EN defined: packet lock. Accept with cli_last=0 sets lock on grant_id;
//   while locked only that client is eligible (others see cli_ready=0 even if valid); accept
//   with cli_last=1 clears lock, and round robin resumes after that client. Reset clears lock.
//  UART_ARB_LOCK_EN undefined: cli_last ignored, no lock register; arbitration per byte.
// TESTING (bench uses the UART transmitter with cnt_MAX=4 for short frames)
//  1 Reset, client 1 valid data 8'hA5 -> cli_ready[1] pulse, next cycle uart_tx_start=1,
//    uart_tx_buf=8'hA5, grant_id=1; decoded tx line carries 0xA5.
//  2 All 4 clients valid continuously (0x10,0x11,0x12,0x13) -> grant order 0,1,2,3,0,...;
//    no accept while uart_tx_ready=0; exactly one uart_tx_start per accept.
//  3 Clients 0 and 2 valid, client 0 drops valid in the cycle before its turn -> client 2
//    granted; rr_ptr unchanged by the withdrawn request.
//  4 Assert rst_n=0 in BUSY mid-frame -> uart_tx_start=0, cli_ready=0 at once; after release
//    no grant until uart_tx_ready=1, then normal service.
//  5 UART_ARB_LOCK_EN: client 3 sends 3 bytes last=0,0,1 while client 0 valid -> bytes 3,3,3
//    then client 0; without the macro -> 3,0,3,0,3 interleave.
//  6 Single client 2 valid for 5 bytes -> 5 consecutive grants to client 2, each launched
//    in the cycle after accept.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one 8N1 UART transmitter between NUM_CLI byte producers. Clients
// are served round robin, one byte per grant. A byte is accepted through
// cli_valid/cli_ready, launched with a one-cycle uart_tx_start, and no new
// byte is accepted until the transmitter reports idle again.
//
// FSM: IDLE (grant when transmitter idle) -> START (launch pulse) ->
//      BUSY (wait for transmitter idle) -> IDLE.
//
// Optional feature (compile-time macro UART_ARB_LOCK_EN):
//   Packet lock. An accepted byte with cli_last=0 locks arbitration onto
//   that client until it delivers a byte with cli_last=1. Without the macro
//   cli_last is ignored and arbitration is per byte.
//
// Parameters:
//   NUM_CLI        number of clients (2..8)
//   ID_W           width of grant_id, at least clog2(NUM_CLI)
//
// Ports:
//   clk            system clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   cli_valid      per-client byte available
//   cli_data       packed client bytes, client i on [8*i +: 8]
//   cli_last       per-client last-byte-of-packet flag (lock feature only)
//   cli_ready      one-hot accept, combinational in the accept cycle
//   uart_tx_start  one-cycle launch pulse to the transmitter
//   uart_tx_buf    byte to transmit, held until the next accept
//   uart_tx_ready  transmitter idle
//   grant_id       client index of the last accepted byte
//   busy           high while in START or BUSY
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_CLI = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLI-1:0]     cli_valid,
    input  logic [8*NUM_CLI-1:0]   cli_data,
    input  logic [NUM_CLI-1:0]     cli_last,
    output logic [NUM_CLI-1:0]     cli_ready,
    output logic                   uart_tx_start,
    output logic [7:0]             uart_tx_buf,
    input  logic                   uart_tx_ready,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [7:0]           buf_q, buf_d;
    logic [ID_W-1:0]      gid_q, gid_d;

    logic [NUM_CLI-1:0]   elig;
    logic                 win_vld;
    logic [ID_W-1:0]      win_idx;
    logic [NUM_CLI-1:0]   win_oh;
    logic [7:0]           win_data;
    logic                 grant;

`ifdef UART_ARB_LOCK_EN
    logic                 lock_q, lock_d;

    // While locked only the client that opened the packet may be granted.
    always_comb begin
        elig = cli_valid;
        if (lock_q) begin
            for (int i = 0; i < NUM_CLI; i++) begin
                if (ID_W'(i) != gid_q) begin
                    elig = elig & ~(NUM_CLI'(1) << i);
                end
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (grant) begin
            lock_d = ~|(cli_last & win_oh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_cli_last;
    assign unused_cli_last = ^cli_last;

    always_comb begin
        elig = cli_valid;
    end
`endif

    // Round-robin pick: scan from the client after rr_ptr, wrapping, and
    // take the first eligible one. rr_ptr itself is checked last, so a lone
    // requester wins on every opportunity.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_CLI; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CLI;
            if (!win_vld && |(elig & (NUM_CLI'(1) << idx))) begin
                win_vld = 1'b1;
                win_idx = ID_W'(idx);
            end
        end
    end

    assign win_oh   = NUM_CLI'(1) << win_idx;
    assign win_data = 8'(cli_data >> (8 * int'(win_idx)));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        buf_d    = buf_q;
        gid_d    = gid_q;
        grant    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (uart_tx_ready && win_vld) begin
                    grant    = 1'b1;
                    buf_d    = win_data;
                    gid_d    = win_idx;
                    rr_ptr_d = win_idx;
                    state_d  = S_START;
                end
            end
            S_START: begin
                // The transmitter drops ready while start is high, so its
                // ready is meaningless here.
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (uart_tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= ID_W'(NUM_CLI - 1);
            buf_q    <= 8'h00;
            gid_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            buf_q    <= buf_d;
            gid_q    <= gid_d;
        end
    end

    // cli_ready is combinational from state; gating with rst_n keeps it low
    // while reset is held even though the state register already reads IDLE.
    assign cli_ready     = (grant && rst_n) ? win_oh : '0;
    assign uart_tx_start = (state_q == S_START);
    assign busy          = (state_q != S_IDLE);
    assign uart_tx_buf   = buf_q;
    assign grant_id      = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NC = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NC-1:0]   cli_valid = '0;
    logic [8*NC-1:0] cli_data = '0;
    logic [NC-1:0]   cli_last = '0;
    logic [NC-1:0]   cli_ready;
    logic            uart_tx_start;
    logic [7:0]      uart_tx_buf;
    logic            uart_tx_ready;
    logic [IW-1:0]   grant_id;
    logic            busy;

    uart_tx_arbiter #(.NUM_CLI(NC), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .cli_valid(cli_valid), .cli_data(cli_data),
        .cli_last(cli_last), .cli_ready(cli_ready), .uart_tx_start(uart_tx_start),
        .uart_tx_buf(uart_tx_buf), .uart_tx_ready(uart_tx_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: 8N1, 4 clocks per bit, not affected by rst_n.
    logic       tx_run = 1'b0;
    logic [9:0] tx_sh = 10'h3FF;
    logic [1:0] tx_cnt = 2'd0;
    logic [3:0] tx_bit = 4'd0;
    logic       tx_line;

    always @(posedge clk) begin
        if (!tx_run) begin
            if (uart_tx_start) begin
                tx_run <= 1'b1;
                tx_sh  <= {1'b1, uart_tx_buf, 1'b0};
                tx_cnt <= 2'd0;
                tx_bit <= 4'd0;
            end
        end else if (tx_cnt == 2'd3) begin
            tx_cnt <= 2'd0;
            tx_sh  <= {1'b1, tx_sh[9:1]};
            if (tx_bit == 4'd9) tx_run <= 1'b0;
            else tx_bit <= tx_bit + 4'd1;
        end else begin
            tx_cnt <= tx_cnt + 2'd1;
        end
    end

    assign tx_line       = tx_run ? tx_sh[0] : 1'b1;
    assign uart_tx_ready = !tx_run && !uart_tx_start;

    // Scoreboard
    typedef struct {
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] line_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_byte(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.d  = d;
        exp_q.push_back(e);
        line_q.push_back(d);
    endtask

    // Client driver: per-client byte queues, updated just after each edge.
    logic [7:0] cq[NC][$];
    logic       cl[NC][$];
    logic [NC-1:0] hold = '0;

    task automatic push(input int c, input logic [7:0] d, input logic last);
        cq[c].push_back(d);
        cl[c].push_back(last);
    endtask

    initial begin
        logic [NC-1:0] hs;
        logic [7:0]    dd;
        logic          ll;
        forever begin
            @(negedge clk);
            hs = cli_valid & cli_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (hs[i] && cq[i].size() > 0) begin
                    dd = cq[i].pop_front();
                    ll = cl[i].pop_front();
                end
            end
            for (int i = 0; i < NC; i++) begin
                cli_valid[i]       = (cq[i].size() > 0) && !hold[i];
                cli_data[8*i +: 8] = (cq[i].size() > 0) ? cq[i][0] : 8'h00;
                cli_last[i]        = (cl[i].size() > 0) ? cl[i][0] : 1'b0;
            end
        end
    end

    // Monitor: launch checks against the scoreboard plus handshake rules.
    initial begin
        logic acc_prev;
        exp_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            chk("start_after_accept", {31'd0, uart_tx_start}, {31'd0, acc_prev});
            if (uart_tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_launch", {24'd0, uart_tx_buf}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", {30'd0, grant_id}, {30'd0, e.id});
                    chk("tx_buf", {24'd0, uart_tx_buf}, {24'd0, e.d});
                end
            end
            chk("ready_onehot", {31'd0, $onehot0(cli_ready)}, 32'd1);
            chk("ready_no_valid", {28'd0, cli_ready & ~cli_valid}, 32'd0);
            chk("ready_in_busy", {31'd0, busy && |cli_ready}, 32'd0);
            chk("ready_tx_busy", {31'd0, !uart_tx_ready && |cli_ready}, 32'd0);
            acc_prev = |(cli_valid & cli_ready);
        end
    end

    // Serial decoder on the transmitter line.
    initial begin
        logic [7:0] rx;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (tx_line == 1'b0) begin
                repeat (5) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    rx[b] = tx_line;
                    if (b < 7) repeat (4) @(negedge clk);
                end
                repeat (4) @(negedge clk);
                chk("rx_stop", {31'd0, tx_line}, 32'd1);
                if (line_q.size() == 0) begin
                    chk("rx_unexpected", {24'd0, rx}, 32'hFFFF_FFFF);
                end else begin
                    want = line_q.pop_front();
                    chk("rx_byte", {24'd0, rx}, {24'd0, want});
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(exp_q.size() == 0 && line_q.size() == 0 && !tx_run && !busy)) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", name}, {31'd0, exp_q.size() == 0 && line_q.size() == 0 && !tx_run && !busy}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (n < 300 && !busy) begin
            @(negedge clk);
            n++;
        end
        chk({"wait_busy_", name}, {31'd0, busy}, 32'd1);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // 1: reset state, then single byte from client 1
        push(1, 8'hA5, 1'b1);
        expect_byte(2'd1, 8'hA5);
        repeat (3) @(negedge clk);
        chk("rst_ready", {28'd0, cli_ready}, 32'd0);
        chk("rst_start", {31'd0, uart_tx_start}, 32'd0);
        chk("rst_buf", {24'd0, uart_tx_buf}, 32'd0);
        chk("rst_gid", {30'd0, grant_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid_seen", {28'd0, cli_valid}, 32'h2);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_ready", {28'd0, cli_ready}, 32'h2);
        @(negedge clk);
        chk("t1_start", {31'd0, uart_tx_start}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        drain("t1");

        // 2: all clients valid, round robin 0,1,2,3,0,1,2,3
        reset_dut();
        for (int c = 0; c < NC; c++) begin
            push(c, 8'h10 + 8'(c), 1'b1);
            push(c, 8'h10 + 8'(c), 1'b1);
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) expect_byte(2'(c), 8'h10 + 8'(c));
        drain("t2");

        // 3: client 0 withdraws just before its turn; client 2 served instead
        reset_dut();
        push(3, 8'h30, 1'b1);
        expect_byte(2'd3, 8'h30);
        expect_byte(2'd2, 8'h21);
        expect_byte(2'd0, 8'h01);
        expect_byte(2'd2, 8'h22);
        wait_busy("t3");
        push(0, 8'h01, 1'b1);
        push(2, 8'h21, 1'b1);
        push(2, 8'h22, 1'b1);
        n = 0;
        while (n < 300 && !(busy && uart_tx_ready)) begin
            @(negedge clk);
            n++;
        end
        chk("t3_wait_end", {31'd0, busy && uart_tx_ready}, 32'd1);
        hold[0] = 1'b1;
        n = 0;
        while (n < 300 && !uart_tx_start) begin
            @(negedge clk);
            n++;
        end
        chk("t3_gid_after_drop", {30'd0, grant_id}, 32'd2);
        hold[0] = 1'b0;
        drain("t3");

        // 4: reset mid-frame, then wait for transmitter idle before granting
        reset_dut();
        push(1, 8'h4A, 1'b1);
        push(1, 8'h4B, 1'b1);
        expect_byte(2'd1, 8'h4A);
        expect_byte(2'd1, 8'h4B);
        wait_busy("t4");
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_start", {31'd0, uart_tx_start}, 32'd0);
        chk("t4_rst_ready", {28'd0, cli_ready}, 32'd0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t4_no_grant_ready", {28'd0, cli_ready}, 32'd0);
        chk("t4_valid_held", {31'd0, cli_valid[1]}, 32'd1);
        drain("t4");

        // 5: packet lock (or per-byte interleave without the feature)
        reset_dut();
        push(2, 8'h20, 1'b1);
        expect_byte(2'd2, 8'h20);
        wait_busy("t5");
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b1);
        push(0, 8'h01, 1'b1);
        push(0, 8'h02, 1'b1);
`ifdef UART_ARB_LOCK_EN
        expect_byte(2'd3, 8'h31);
        expect_byte(2'd3, 8'h32);
        expect_byte(2'd3, 8'h33);
        expect_byte(2'd0, 8'h01);
        expect_byte(2'd0, 8'h02);
`else
        expect_byte(2'd3, 8'h31);
        expect_byte(2'd0, 8'h01);
        expect_byte(2'd3, 8'h32);
        expect_byte(2'd0, 8'h02);
        expect_byte(2'd3, 8'h33);
`endif
        drain("t5");

        // 6: lone client 2, five consecutive grants
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            push(2, 8'h61 + 8'(k), 1'b1);
            expect_byte(2'd2, 8'h61 + 8'(k));
        end
        drain("t6");

        chk("leftover_expected", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
